// File: rtl/shift_sequencer_if.sv
// Host command interface for shift_sequencer.
// master: command source (start, cmd, count, data, ser_in); observes busy, done, last_out.
// slave : sequencer side of the same handshake.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
);
  logic             start;
  logic [2:0]       cmd;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data;
  logic             ser_in;
  logic             busy;
  logic             done;
  logic             last_out;

  modport master (
    output start, cmd, count, data, ser_in,
    input  busy, done, last_out
  );

  modport slave (
    input  start, cmd, count, data, ser_in,
    output busy, done, last_out
  );
endinterface

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for an external universal shift register
// (sel 00 load, 01 shift right, 10 shift left, 11 hold).
// Ports: clk, rst (async active-low); host command handshake via
// shift_sequencer_if.slave; pout = register contents in; sel/sin/pin drive
// the register.
module shift_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  shift_sequencer_if.slave host,
  input  logic [WIDTH-1:0] pout,
  output logic [1:0]       sel,
  output logic             sin,
  output logic [WIDTH-1:0] pin
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam logic [1:0] SEL_LOAD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_HOLD  = 2'b11;

  logic [1:0]       state, state_d;
  logic [2:0]       op, op_d;
  logic [CNT_W-1:0] rem, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  // State and command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      op     <= OP_NOP;
      rem    <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_d;
      op     <= op_d;
      rem    <= rem_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  // Next-state: command capture, step counting, shifted-out bit capture
  always_comb begin
    state_d = state;
    op_d    = op;
    rem_d   = rem;
    data_d  = data_q;
    last_d  = last_q;
    case (state)
      S_IDLE: begin
        if (host.start) begin
          data_d = host.data;
          case (host.cmd)
            OP_LOAD: begin
              op_d    = OP_LOAD;
              rem_d   = CNT_W'(1);
              state_d = S_EXEC;
            end
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
              op_d    = host.cmd;
              rem_d   = host.count;
              // zero-step shifts complete without touching the register
              state_d = (host.count != '0) ? S_EXEC : S_DONE;
            end
            default: begin
              op_d    = OP_NOP;
              rem_d   = '0;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_EXEC: begin
        case (op)
          OP_SHR, OP_ROR: last_d = pout[0];
          OP_SHL, OP_ROL: last_d = pout[WIDTH-1];
          default:        last_d = last_q;
        endcase
        // rem is never taken below its final step
        if (rem > CNT_W'(1)) begin
          rem_d = rem - CNT_W'(1);
        end else begin
          rem_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register drive: only EXEC issues an edge; all other states hold
  always_comb begin
    sel = SEL_HOLD;
    sin = 1'b0;
    pin = '0;
    if (state == S_EXEC) begin
      pin = data_q;
      case (op)
        OP_LOAD: sel = SEL_LOAD;
        OP_SHR:  begin sel = SEL_RIGHT; sin = host.ser_in;   end
        OP_ROR:  begin sel = SEL_RIGHT; sin = pout[0];       end
        OP_SHL:  begin sel = SEL_LEFT;  sin = host.ser_in;   end
        OP_ROL:  begin sel = SEL_LEFT;  sin = pout[WIDTH-1]; end
        default: sel = SEL_HOLD;
      endcase
    end
  end

  assign host.busy     = (state != S_IDLE);
  assign host.done     = (state == S_DONE);
  assign host.last_out = last_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural 4-bit shift
// register on the datapath side and a scoreboard of expected command results.
module tb_shift_sequencer;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  localparam logic [2:0] C_LOAD = 3'd0;
  localparam logic [2:0] C_SHR  = 3'd1;
  localparam logic [2:0] C_SHL  = 3'd2;
  localparam logic [2:0] C_ROR  = 3'd3;
  localparam logic [2:0] C_ROL  = 3'd4;
  localparam logic [2:0] C_NOP  = 3'd6;

  typedef struct {
    logic [WIDTH-1:0] pout;
    logic             last;
    int               exec;
    int               busy;
    logic [1:0]       sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) hif ();

  logic [WIDTH-1:0] pout = '0;
  logic [WIDTH-1:0] pin;
  logic [1:0]       sel;
  logic             sin;

  shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (hif),
    .pout (pout),
    .sel  (sel),
    .sin  (sin),
    .pin  (pin)
  );

  // Universal shift register driven by the sequencer
  always @(posedge clk) begin
    case (sel)
      2'b00:   pout <= pin;
      2'b01:   pout <= {sin, pout[WIDTH-1:1]};
      2'b10:   pout <= {pout[WIDTH-2:0], sin};
      default: pout <= pout;
    endcase
  end

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic model_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [2:0] c, input logic [2:0] n,
                         input logic [3:0] d, input logic si, input bit poke);
    exp_t       e;
    logic [3:0] p;
    logic       l;
    int         steps;
    int         busy_cnt;
    int         exec_cnt;
    bit         got_done;
    logic       exp_sin;
    p = pout;
    l = model_last;
    if (c == C_LOAD) steps = 1;
    else if (c >= C_SHR && c <= C_ROL) steps = int'(n);
    else steps = 0;
    case (c)
      C_LOAD:       e.sel = 2'b00;
      C_SHR, C_ROR: e.sel = 2'b01;
      C_SHL, C_ROL: e.sel = 2'b10;
      default:      e.sel = 2'b11;
    endcase
    for (int k = 0; k < steps; k++) begin
      case (c)
        C_LOAD: p = d;
        C_SHR:  begin l = p[0]; p = {si, p[3:1]};   end
        C_SHL:  begin l = p[3]; p = {p[2:0], si};   end
        C_ROR:  begin l = p[0]; p = {p[0], p[3:1]}; end
        C_ROL:  begin l = p[3]; p = {p[2:0], p[3]}; end
        default: ;
      endcase
    end
    e.pout = p;
    e.last = l;
    e.exec = steps;
    e.busy = steps + 1;
    sb.push_back(e);
    model_last = l;

    hif.cmd    = c;
    hif.count  = n;
    hif.data   = d;
    hif.ser_in = si;
    hif.start  = 1'b1;
    step();
    hif.start = 1'b0;

    busy_cnt = 0;
    exec_cnt = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (poke && i == 1) begin
        hif.start = 1'b1;
        hif.cmd   = C_LOAD;
        hif.data  = ~d;
      end
      if (poke && i == 2) hif.start = 1'b0;
      if (hif.busy) busy_cnt++;
      if (sel != 2'b11) begin
        exec_cnt++;
        chk("sel", 32'(sel), 32'(e.sel));
        chk("pin", 32'(pin), 32'(d));
        if (c != C_LOAD) begin
          case (c)
            C_ROR:   exp_sin = pout[0];
            C_ROL:   exp_sin = pout[3];
            default: exp_sin = si;
          endcase
          chk("sin", 32'(sin), 32'(exp_sin));
        end
      end
      if (hif.done) got_done = 1'b1;
      else step();
    end
    hif.start = 1'b0;

    e = sb.pop_front();
    chk("done_seen", 32'(got_done), 32'(1));
    chk("busy_cycles", 32'(busy_cnt), 32'(e.busy));
    chk("exec_cycles", 32'(exec_cnt), 32'(e.exec));
    chk("pout", 32'(pout), 32'(e.pout));
    chk("last_out", 32'(hif.last_out), 32'(e.last));
    step();
    chk("idle_busy", 32'(hif.busy), 32'(0));
    chk("idle_done", 32'(hif.done), 32'(0));
    chk("idle_sel", 32'(sel), 32'(3));
  endtask

  initial begin
    hif.start  = 1'b0;
    hif.cmd    = C_NOP;
    hif.count  = '0;
    hif.data   = '0;
    hif.ser_in = 1'b0;
    rst        = 1'b0;
    step();
    step();
    chk("rst_sel", 32'(sel), 32'(3));
    chk("rst_busy", 32'(hif.busy), 32'(0));
    chk("rst_done", 32'(hif.done), 32'(0));
    chk("rst_last", 32'(hif.last_out), 32'(0));
    chk("rst_pin", 32'(pin), 32'(0));
    chk("rst_sin", 32'(sin), 32'(0));
    rst = 1'b1;
    step();

    run_cmd(C_LOAD, 3'd0, 4'b1011, 1'b0, 1'b0);
    run_cmd(C_SHR,  3'd3, 4'b0000, 1'b1, 1'b0);
    run_cmd(C_LOAD, 3'd5, 4'b1000, 1'b0, 1'b0);
    run_cmd(C_ROL,  3'd5, 4'b0000, 1'b0, 1'b0);
    run_cmd(C_SHL,  3'd0, 4'b0000, 1'b1, 1'b0);
    run_cmd(C_NOP,  3'd4, 4'b1111, 1'b0, 1'b0);
    run_cmd(C_LOAD, 3'd0, 4'b0110, 1'b0, 1'b0);
    run_cmd(C_ROR,  3'd2, 4'b0000, 1'b0, 1'b0);
    run_cmd(C_SHR,  3'd3, 4'b0101, 1'b0, 1'b1);
    run_cmd(C_LOAD, 3'd0, 4'b1001, 1'b0, 1'b0);
    run_cmd(C_SHL,  3'd7, 4'b0000, 1'b1, 1'b0);

    // Reset in the middle of a long rotate
    hif.cmd   = C_ROR;
    hif.count = 3'd7;
    hif.start = 1'b1;
    step();
    hif.start = 1'b0;
    step();
    step();
    chk("pre_rst_busy", 32'(hif.busy), 32'(1));
    rst = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'(3));
    chk("arst_busy", 32'(hif.busy), 32'(0));
    chk("arst_done", 32'(hif.done), 32'(0));
    chk("arst_last", 32'(hif.last_out), 32'(0));
    model_last = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_sel", 32'(sel), 32'(3));
      chk("post_rst_busy", 32'(hif.busy), 32'(0));
    end

    run_cmd(C_LOAD, 3'd0, 4'b1100, 1'b0, 1'b0);
    run_cmd(C_ROR,  3'd1, 4'b0000, 1'b0, 1'b0);
    run_cmd(C_ROL,  3'd3, 4'b0000, 1'b0, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
